// File: rtl/f33m_multiplier_if.sv
// Operand/result bundle for the GF(3^291) multiplier: two extension-field
// operands in, one product plus its sticky completion flag out.
interface f33m_multiplier_if;
    logic [581:0] a;
    logic [581:0] b;
    logic [581:0] c;
    logic         done;

    // Not a streaming handshake: a/b are sampled once on the first edge after
    // reset releases; done rises with c valid and both stay put until reset.
    modport master (output a, output b, input c, input done);
    modport slave  (input a, input b, output c, output done);
endinterface

// File: rtl/f33m_multiplier.sv
// Karatsuba multiplier in GF(3^97)[y]/(y^3 - y - 1): six base-field products
// evaluated one after another on a single trit-serial GF(3^97) multiplier.
module f33m_multiplier (
    input  logic                    clk,
    input  logic                    reset,
    f33m_multiplier_if.slave        bus,
    output logic [3:0]              dbg_state
);
    localparam int W  = 193;
    localparam int W3 = 581;
    localparam int M  = 97;

    typedef logic [W:0] fe_t;
    typedef enum logic [3:0] {
        IDLE, MUL0, MUL1, MUL2, MUL3, MUL4, MUL5, FINISH, DONE
    } state_t;

    function automatic logic [1:0] trit_add(input logic [1:0] x, input logic [1:0] y);
        logic [2:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= 3'd3) s = s - 3'd3;
        return s[1:0];
    endfunction

    function automatic fe_t fe_add(input fe_t x, input fe_t y);
        fe_t r;
        for (int i = 0; i < M; i++) r[2*i +: 2] = trit_add(x[2*i +: 2], y[2*i +: 2]);
        return r;
    endfunction

    // Negation swaps the codes for 1 and 2; 0 stays 0.
    function automatic fe_t fe_neg(input fe_t x);
        fe_t r;
        for (int i = 0; i < M; i++) r[2*i +: 2] = {x[2*i], x[2*i+1]};
        return r;
    endfunction

    function automatic fe_t fe_sub(input fe_t x, input fe_t y);
        return fe_add(x, fe_neg(y));
    endfunction

    function automatic fe_t fe_scale(input fe_t x, input logic [1:0] t);
        case (t)
            2'b01:   return x;
            2'b10:   return fe_neg(x);
            default: return '0;
        endcase
    endfunction

    // Multiply by x; the trit leaving position 96 folds back as x^97 = 2x^12 + 1.
    function automatic fe_t fe_mulx(input fe_t x);
        fe_t        r;
        logic [1:0] top;
        top      = x[W -: 2];
        r        = {x[W-2:0], 2'b00};
        r[1:0]   = top;
        r[25:24] = trit_add(r[25:24], {top[0], top[1]});
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [W3:0] a_q, b_q;
    fe_t         opa_q, opb_q, acc_q;
    fe_t         p_q [6];
    logic [W3:0] c_q;
    logic        done_q;

    fe_t         a0, a1, a2, b0, b1, b2;
    fe_t         sel_a, sel_b, acc_next;
    logic [2:0]  pidx;
    fe_t         d1, d2, d3, c0, c1, c2;

    assign a0 = a_q[W:0];
    assign a1 = a_q[2*W+1:W+1];
    assign a2 = a_q[W3:2*W+2];
    assign b0 = b_q[W:0];
    assign b1 = b_q[2*W+1:W+1];
    assign b2 = b_q[W3:2*W+2];

    // MSB-first Horner step: the multiplier operand shifts toward its top trit.
    assign acc_next = fe_add(fe_mulx(acc_q), fe_scale(opa_q, opb_q[W -: 2]));

    assign d1 = fe_sub(fe_sub(p_q[3], p_q[0]), p_q[1]);
    assign d2 = fe_add(fe_sub(fe_sub(p_q[4], p_q[0]), p_q[2]), p_q[1]);
    assign d3 = fe_sub(fe_sub(p_q[5], p_q[1]), p_q[2]);
    assign c0 = fe_add(p_q[0], d3);
    assign c1 = fe_add(fe_add(d1, d3), p_q[2]);
    assign c2 = fe_add(d2, p_q[2]);

    always_comb begin
        pidx  = 3'd0;
        sel_a = a0;
        sel_b = b0;
        case (state_q)
            MUL1: begin pidx = 3'd1; sel_a = a1; sel_b = b1; end
            MUL2: begin pidx = 3'd2; sel_a = a2; sel_b = b2; end
            MUL3: begin pidx = 3'd3; sel_a = fe_add(a0, a1); sel_b = fe_add(b0, b1); end
            MUL4: begin pidx = 3'd4; sel_a = fe_add(a0, a2); sel_b = fe_add(b0, b2); end
            MUL5: begin pidx = 3'd5; sel_a = fe_add(a1, a2); sel_b = fe_add(b1, b2); end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Each product: count 0 loads the operands, counts 1..97 consume one trit each.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                state_d = MUL0;
                cnt_d   = '0;
            end
            MUL0, MUL1, MUL2, MUL3, MUL4, MUL5: begin
                if (cnt_q == 7'd97) begin
                    cnt_d = '0;
                    case (state_q)
                        MUL0:    state_d = MUL1;
                        MUL1:    state_d = MUL2;
                        MUL2:    state_d = MUL3;
                        MUL3:    state_d = MUL4;
                        MUL4:    state_d = MUL5;
                        default: state_d = FINISH;
                    endcase
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            FINISH:  state_d = DONE;
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q    <= '0;
            b_q    <= '0;
            opa_q  <= '0;
            opb_q  <= '0;
            acc_q  <= '0;
            c_q    <= '0;
            done_q <= 1'b0;
            for (int i = 0; i < 6; i++) p_q[i] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    a_q <= bus.a;
                    b_q <= bus.b;
                end
                MUL0, MUL1, MUL2, MUL3, MUL4, MUL5: begin
                    if (cnt_q == 7'd0) begin
                        opa_q <= sel_a;
                        opb_q <= sel_b;
                        acc_q <= '0;
                    end else begin
                        acc_q <= acc_next;
                        opb_q <= {opb_q[W-2:0], 2'b00};
                        if (cnt_q == 7'd97) p_q[pidx] <= acc_next;
                    end
                end
                FINISH: begin
                    c_q    <= {c2, c1, c0};
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.c     = c_q;
    assign bus.done  = done_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_f33m_multiplier.sv
// Directed bench for f33m_multiplier: expected products go into a queue at
// launch and are popped by a monitor when done rises.
module tb_f33m_multiplier;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] dbg_state;

    f33m_multiplier_if bus ();

    f33m_multiplier dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    localparam logic [193:0] ONE = 194'd1;
    localparam logic [193:0] X96 = 194'd1 << 192;
    localparam logic [581:0] RA = {194'ha05199566491a29190482a612a86561469a2a21a0598425a,
                                   194'h29a016819944661925585684aa051456a52a02442a9080568,
                                   194'h15219624104641521626a965848208a09a02a9a084499006a};
    localparam logic [581:0] RB = {194'h16458a4488a64426429a46989868049a5a94a291668056411,
                                   194'h4229659440a9689291461604a9a01a20000a191a00142951,
                                   194'h504004aaa024886a56504a8a4a58806919aa1a4549a56688};
    localparam logic [581:0] RC = {194'ha65a56829a691285518450025a0190642544a08628a965a5,
                                   194'h22889984564568942218aa986112026a095a629a68890a859,
                                   194'h14a11844416485509289802509a000421864454612559588};

    logic [581:0] exp_q[$];
    int           checks = 0;
    int           errors = 0;
    int           pops = 0;
    int           cyc = -1;
    logic         done_prev = 1'b0;

    // Cycle 0 is the first rising edge with reset high.
    always @(posedge clk) begin
        if (!reset) cyc <= -1;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [581:0] act, input logic [581:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && bus.done && !done_prev) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done c=%h", bus.c);
            end else begin
                check("result_c", bus.c, exp_q.pop_front());
                checks++;
                if (cyc != 589) begin
                    errors++;
                    $display("FAIL latency actual=%0d expected=589", cyc);
                end
            end
            pops++;
        end
        done_prev = bus.done;
    end

    function automatic logic [581:0] rand_ext();
        logic [581:0] v;
        v = '0;
        for (int i = 0; i < 291; i++) v[2*i +: 2] = 2'($urandom_range(0, 2));
        return v;
    endfunction

    // Called with reset low; inputs are scrambled right after cycle 0 to
    // confirm the operands were latched.
    task automatic start(input logic [581:0] a, input logic [581:0] b);
        bus.a = a;
        bus.b = b;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        bus.a = rand_ext();
        bus.b = rand_ext();
    endtask

    task automatic wait_done(input string name);
        int p0;
        int n;
        p0 = pops;
        n  = 0;
        while (pops == p0 && n < 700) begin
            @(negedge clk);
            n++;
        end
        if (pops == p0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=no_done required=done_by_589", name);
        end
    endtask

    task automatic hold_and_clear(input string name, input logic [581:0] exp);
        bus.a = rand_ext();
        bus.b = rand_ext();
        repeat (10) @(negedge clk);
        check({name, "_hold_c"}, bus.c, exp);
        check({name, "_hold_done"}, {581'd0, bus.done}, 582'd1);
        reset = 1'b0;
        #1;
        check({name, "_clr_c"}, bus.c, '0);
        check({name, "_clr_done"}, {581'd0, bus.done}, '0);
        repeat (2) @(negedge clk);
    endtask

    task automatic run(input string name, input logic [581:0] a, input logic [581:0] b,
                       input logic [581:0] exp);
        exp_q.push_back(exp);
        start(a, b);
        wait_done(name);
        hold_and_clear(name, exp);
    endtask

    task automatic wait_cycle(input int target);
        int n;
        n = 0;
        while (cyc < target && n < 700) begin
            @(negedge clk);
            n++;
        end
        if (cyc < target) begin
            checks++;
            errors++;
            $display("FAIL wait_cycle actual=%0d required=%0d", cyc, target);
        end
    endtask

    initial begin
        logic [581:0] rb;
        reset = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (3) @(negedge clk);
        check("reset_c", bus.c, '0);
        check("reset_done", {581'd0, bus.done}, '0);

        rb = rand_ext();
        run("identity", {194'd0, 194'd0, ONE}, rb, rb);
        run("zero", '0, rand_ext(), '0);
        run("y_times_y2", {194'd0, ONE, 194'd0}, {ONE, 194'd0, 194'd0}, {194'd0, ONE, ONE});
        run("y2_times_y2", {ONE, 194'd0, 194'd0}, {ONE, 194'd0, 194'd0}, {ONE, ONE, 194'd0});
        run("base_reduce", {194'd0, 194'd0, X96}, {194'd0, 194'd0, 194'h4},
            {194'd0, 194'd0, 194'h2000001});
        run("random", RA, RB, RC);

        // Abort at cycle 300, then a fresh run with swapped operands.
        start(RA, RB);
        wait_cycle(300);
        reset = 1'b0;
        #1;
        check("abort_c", bus.c, '0);
        check("abort_done", {581'd0, bus.done}, '0);
        repeat (2) @(negedge clk);
        run("after_abort", RB, RA, RC);

        // Reset asserted in the cycle whose closing edge would raise done.
        start({194'd0, 194'd0, ONE}, rb);
        wait_cycle(588);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("reset_wins_done", {581'd0, bus.done}, '0);
        check("reset_wins_c", bus.c, '0);
        repeat (3) @(negedge clk);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL leftover_expected actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/f33m_multiplier.md
# f33m_multiplier

Sequential multiplier in the cubic extension field GF(3^{3m}) = GF(3^m)[y]/(y^3 − y − 1), with m = 97 and base field GF(3^97) = GF(3)[x]/(x^97 + x^12 + 2). The block is part of the pairing datapath. It computes c = a·b for two extension-field elements using six base-field products (Karatsuba), evaluated serially on one internal GF(3^m) multiplier. Completion is signalled with a sticky `done`.

## Interface
- Parameters: none; m = 97 and both polynomials are fixed.
- Derived widths: `W` = 193 (one GF(3^m) element = 194 bits); `W3` = 581 (one extension element = 582 bits).
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low; one clock; reset is asynchronous and active-low.
- a  input  582  operand {a2, a1, a0}; a2 = bits [581:388], a1 = [387:194], a0 = [193:0]; value a0 + a1·y + a2·y^2.
- b  input  582  operand, same layout.
- c  output  582  product, same layout.
- done  output  1  high when c is valid.

## Operation
- Trit encoding: trit i of a 194-bit element is at bits [2i+1:2i]. Codes: 00 = 0, 01 = 1, 10 = 2. Code 11 never appears on inputs and is never produced.
- Base-field ops:
  - add/sub: trit-wise mod 3.
  - mul: polynomial product reduced with x^97 = 2x^12 + 1.
  - All results are fully reduced, degree ≤ 96.
- Karatsuba products:
  - p0 = a0b0, p1 = a1b1, p2 = a2b2
  - p3 = (a0+a1)(b0+b1), p4 = (a0+a2)(b0+b2), p5 = (a1+a2)(b1+b2)
- Intermediate terms:
  - d1 = p3 − p0 − p1
  - d2 = p4 − p0 − p2 + p1
  - d3 = p5 − p1 − p2
- Reduction with y^3 = y + 1:
  - c0 = p0 + d3
  - c1 = d1 + d3 + p2
  - c2 = d2 + p2
- Result equals schoolbook a·b mod (y^3 − y − 1).
- One internal GF(3^m) multiplier is used. It is digit-serial: one trit of the multiplier operand per cycle, 97 cycles per product. A small FSM sequences p0..p5 and the sums.
- FSM states:
  - IDLE: entered on reset.
  - MUL0..MUL5: one per product.
  - FINISH: computes c.
  - DONE: holds until reset.
- a and b are sampled on the first rising clk edge after reset deasserts. They are held internally; later input changes are ignored until the next reset.

## Timing
- Reset low (asynchronous):
  - c = 0, done = 0, FSM forced to IDLE.
  - Any operation in progress is aborted with no partial result.
- Start: first rising edge with reset high. Inputs latch here (cycle 0).
- Product k (k = 0..5) occupies 98 cycles: 1 load cycle plus 97 trit cycles.
- FINISH takes 1 cycle. c and done update together on the edge ending FINISH.
- Latency: done rises exactly 6·98 + 1 = 589 cycles after the start edge.
- c is never visible in partial form; it changes only at that edge.
- DONE state:
  - done stays 1 and c stays constant until reset is asserted.
  - No new operation starts without a reset cycle.
- Reset asserted in the same cycle done would rise: reset wins, done stays 0.

## Test plan
- Identity:
  - Stimulus: a = {0,0,1}, b = arbitrary valid element.
  - Required response: after 589 cycles, done = 1 and c = b.
- Zero:
  - Stimulus: a = 0, b = arbitrary.
  - Required response: c = 0, done = 1 at cycle 589.
- y-reduction:
  - Stimulus: a = {0,1,0} (y), b = {1,0,0} (y^2).
  - Required response: c = {0,1,1}, i.e. y + 1. Also check a = b = {1,0,0} gives c = {0,1,1}·y = {1,1,0}.
- Base-field reduction:
  - Stimulus: a0 = x^96 (bits [193:192] = 01), b0 = x (bits [3:2] = 01), other parts 0.
  - Required response: c0 = 2x^12 + 1 (bits [25:24] = 10, bits [1:0] = 01).
- Random vector:
  - Stimulus:
    - a = {a05199566491a29190482a612a86561469a2a21a0598425a, 29a016819944661925585684aa051456a52a02442a9080568, 15219624104641521626a965848208a09a02a9a084499006a}
    - b = {16458a4488a64426429a46989868049a5a94a291668056411, 4229659440a9689291461604a9a01a20000a191a00142951, 504004aaa024886a56504a8a4a58806919aa1a4549a56688}
  - Required response: c = {a65a56829a691285518450025a0190642544a08628a965a5, 22889984564568942218aa986112026a095a629a68890a859, 14a11844416485509289802509a000421864454612559588}.
- Reset mid-operation:
  - Stimulus: assert reset at cycle 300.
  - Required response: done = 0 and c = 0 immediately. After release, a full 589-cycle run yields the correct product for the new a and b.
